// File: rtl/core_ctrl_pkg.sv
// Shared types for the core run controller.
// State encoding, halt causes and default widths.
package core_ctrl_pkg;

  localparam int CNT_W_DEF   = 32;
  localparam int RST_CYC_DEF = 2;
  localparam int PC_W        = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } run_state_t;

  typedef logic [1:0] hcause_t;

  localparam hcause_t HC_NONE    = 2'd0;
  localparam hcause_t HC_ECALL   = 2'd1;
  localparam hcause_t HC_EBREAK  = 2'd2;
  localparam hcause_t HC_TIMEOUT = 2'd3;

  function automatic int rst_len(input int n);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/run_cycle_cnt.sv
// Saturating, enable-gated run cycle counter.
// o_nxt is the value the counter takes on the next enabled edge.
module run_cycle_cnt #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_nxt
);

  logic [W-1:0] r_cnt;

  assign o_nxt = (&r_cnt) ? r_cnt : r_cnt + W'(1);
  assign o_cnt = r_cnt;

  // clear on launch, advance on enabled run cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= o_nxt;
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Core run controller: reset sequencing, run, halt capture.
// Optional single-step ports with CORE_RUN_CTRL_STEP_EN.
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = RST_CYC_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic [CNT_W-1:0] timeout_limit,
  input  logic             ecall_pulse,
  input  logic             ebreak_pulse,
  input  logic [PC_W-1:0]  pc,
  output logic             core_rst,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic [1:0]       halt_cause,
  output logic [PC_W-1:0]  halt_pc,
  output logic [CNT_W-1:0] cycle_cnt
`ifdef CORE_RUN_CTRL_STEP_EN
  ,
  input  logic             step,
  input  logic             step_mode
`endif
);

  localparam int RC = rst_len(RST_CYCLES);
  localparam int RW = $clog2(RC + 1);
  localparam logic [RW-1:0] RC_LAST = RW'(RC - 1);

  run_state_t       r_state;
  run_state_t       w_state_nxt;
  logic [RW-1:0]    r_rcnt;
  hcause_t          r_cause;
  logic [PC_W-1:0]  r_hpc;
  logic [CNT_W-1:0] w_nxt;
  logic [CNT_W-1:0] w_cnt;
  logic             w_step_ok;
  logic             w_adv;
  logic             w_launch;
  logic             w_hit_to;
  logic             w_halt;
  hcause_t          w_cause;

`ifdef CORE_RUN_CTRL_STEP_EN
  assign w_step_ok = step_mode ? step : 1'b1;
`else
  assign w_step_ok = 1'b1;
`endif

  assign w_adv    = (r_state == ST_RUN) && w_step_ok;
  assign w_launch = (r_state == ST_IDLE) && start;
  assign w_hit_to = w_adv && (timeout_limit != '0)
                  && (w_nxt == timeout_limit);
  assign w_halt   = w_adv && (ecall_pulse || ebreak_pulse || w_hit_to);

  run_cycle_cnt #(.W(CNT_W)) u_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (w_launch),
    .i_en    (w_adv),
    .o_cnt   (w_cnt),
    .o_nxt   (w_nxt)
  );

  // halt cause priority: ebreak, ecall, timeout
  always_comb begin
    w_cause = HC_NONE;
    if (ebreak_pulse)     w_cause = HC_EBREAK;
    else if (ecall_pulse) w_cause = HC_ECALL;
    else if (w_hit_to)    w_cause = HC_TIMEOUT;
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RESET;
      ST_RESET: if (r_rcnt == RC_LAST) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_halt) w_state_nxt = ST_HALT;
      ST_HALT:  if (clear) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // core reset hold counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     r_rcnt <= '0;
    else if (r_state != ST_RESET) r_rcnt <= '0;
    else if (r_rcnt != RC_LAST)   r_rcnt <= r_rcnt + RW'(1);
  end

  // halt capture; cleared on launch, kept through clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cause <= HC_NONE;
      r_hpc   <= '0;
    end else if (w_launch) begin
      r_cause <= HC_NONE;
      r_hpc   <= '0;
    end else if (w_halt) begin
      r_cause <= w_cause;
      r_hpc   <= pc;
    end
  end

  assign core_rst   = (r_state == ST_IDLE) || (r_state == ST_RESET);
  assign core_en    = w_adv;
  assign busy       = (r_state == ST_RESET) || (r_state == ST_RUN);
  assign done       = (r_state == ST_HALT);
  assign halt_cause = r_cause;
  assign halt_pc    = r_hpc;
  assign cycle_cnt  = w_cnt;

endmodule
